// File: rtl/fixdiv_pkg.sv
// -----------------------------------------------------------------------------
// fixdiv_pkg
// Shared types and width helpers for the fixdiv_hs fixed-point divider.
//   rmode_t : rounding mode encoding (value 3 is treated as truncate)
//   state_t : divider control states
//   qw_of / iter_of / cnt_w_of : derived widths used by the datapath
// Optional feature macro: FIXDIV_ROUND_EN (adds the guard iteration so the
// rounding modes can be honoured; without it the divider always truncates).
// -----------------------------------------------------------------------------
package fixdiv_pkg;

   typedef enum logic [1:0] {
      RM_TRUNC = 2'd0,
      RM_RNE   = 2'd1,
      RM_RNA   = 2'd2
   } rmode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Quotient magnitude bits: integer part plus fractional part.
   function automatic int qw_of(input int width, input int fbits);
      return width + fbits;
   endfunction

   // Restoring steps per division; the guard bit costs one extra step.
   function automatic int iter_of(input int width, input int fbits);
`ifdef FIXDIV_ROUND_EN
      return width + fbits + 1;
`else
      return width + fbits;
`endif
   endfunction

   // Step counter width, with one spare bit of headroom.
   function automatic int cnt_w_of(input int iter);
      return $clog2(iter + 1) + 1;
   endfunction

endpackage

// File: rtl/fixdiv_hs_if.sv
// -----------------------------------------------------------------------------
// fixdiv_hs_if
// Operand/result stream bundle for fixdiv_hs.
//   in_valid/in_ready   : operand handshake
//   a, b                : dividend, divisor (WIDTH bits)
//   uns                 : 1 = unsigned, 0 = two's complement
//   rmode               : rounding mode (see fixdiv_pkg::rmode_t)
//   out_valid/out_ready : result handshake
//   val, dbz, ovf       : quotient and status flags (qualified by out_valid)
// Modports: master = producer of operands / consumer of results,
//           slave  = the divider.
// -----------------------------------------------------------------------------
interface fixdiv_hs_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             uns;
   logic [1:0]       rmode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] val;
   logic             dbz;
   logic             ovf;

   modport master (
      output in_valid, a, b, uns, rmode, out_ready,
      input  in_ready, out_valid, val, dbz, ovf
   );

   modport slave (
      input  in_valid, a, b, uns, rmode, out_ready,
      output in_ready, out_valid, val, dbz, ovf
   );

endinterface

// File: rtl/fixdiv_round.sv
// -----------------------------------------------------------------------------
// fixdiv_round
// Combinational rounding and range check of an unsigned quotient magnitude.
//   q     in  QW     quotient magnitude (truncated)
//   g     in  1      guard bit (first discarded bit)
//   s     in  1      sticky bit (any remainder below the guard)
//   rmode in  2      rounding mode (RM_TRUNC / RM_RNE / RM_RNA, 3 = truncate)
//   neg   in  1      result is negative
//   uns   in  1      unsigned result range
//   val   out WIDTH  signed/unsigned result, zero when out of range
//   ovf   out 1      rounded magnitude does not fit the result range
// -----------------------------------------------------------------------------
module fixdiv_round
   import fixdiv_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int QW    = 24
) (
   input  logic [QW-1:0]    q,
   input  logic             g,
   input  logic             s,
   input  logic [1:0]       rmode,
   input  logic             neg,
   input  logic             uns,
   output logic [WIDTH-1:0] val,
   output logic             ovf
);

   logic             inc;
   logic [QW:0]      m;
   logic [WIDTH-1:0] mt;
   logic             over_uns;
   logic             over_pos;
   logic             over_neg;

   always_comb begin
      inc = 1'b0;
      case (rmode)
         RM_RNE:  inc = g & (s | q[0]);
         RM_RNA:  inc = g;
         default: inc = 1'b0;
      endcase
   end

   // One extra bit so the rounding carry cannot wrap.
   assign m  = {1'b0, q} + {{QW{1'b0}}, inc};
   assign mt = m[WIDTH-1:0];

   // m > 2^WIDTH-1
   assign over_uns = |m[QW:WIDTH];
   // m > 2^(WIDTH-1)-1
   assign over_pos = |m[QW:WIDTH-1];
   // m > 2^(WIDTH-1): exactly 2^(WIDTH-1) is the most negative value and fits
   assign over_neg = (|m[QW:WIDTH]) | (m[WIDTH-1] & (|m[WIDTH-2:0]));

   always_comb begin
      if (uns) begin
         ovf = over_uns;
      end else if (neg) begin
         ovf = over_neg;
      end else begin
         ovf = over_pos;
      end
      if (ovf) begin
         val = '0;
      end else if (neg) begin
         // Negating zero yields zero, so a zero result never carries a sign.
         val = -mt;
      end else begin
         val = mt;
      end
   end

endmodule

// File: rtl/fixdiv_hs.sv
// -----------------------------------------------------------------------------
// fixdiv_hs
// Sequential signed/unsigned fixed-point divider, val = (a << FBITS) / b,
// one restoring step per clock, with valid/ready handshakes on both sides.
//   clk   in  1  clock
//   rst_n in  1  asynchronous active-low reset (aborts any operation)
//   bus   slave modport of fixdiv_hs_if (operands, rounding mode, result)
// Parameters: WIDTH (>= 4) operand/result width, FBITS (0..WIDTH-1) fraction.
// Optional feature macro: FIXDIV_ROUND_EN. When defined an extra guard step
// is computed and rmode is honoured; otherwise results truncate toward zero
// and the divide takes one cycle less.
// The interface instance must be built with the same WIDTH as this module.
// -----------------------------------------------------------------------------
module fixdiv_hs
   import fixdiv_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FBITS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   fixdiv_hs_if.slave bus
);

   localparam int QW   = qw_of(WIDTH, FBITS);
   localparam int ITER = iter_of(WIDTH, FBITS);
   localparam int CW   = cnt_w_of(ITER);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] bu_reg, bu_next;
   // Holds the shifted dividend; quotient bits enter at the bottom as the
   // dividend bits leave at the top, so it ends up holding the quotient.
   logic [ITER-1:0]  wq_reg, wq_next;
   logic [WIDTH:0]   acc_reg, acc_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             neg_reg, neg_next;
   logic             uns_reg, uns_next;
   logic             dbz_pend_reg, dbz_pend_next;
   logic [1:0]       rmode_reg, rmode_next;
   logic [WIDTH-1:0] val_reg, val_next;
   logic             dbz_reg, dbz_next;
   logic             ovf_reg, ovf_next;

   // Operand magnitudes. WIDTH bits are enough even for the most negative
   // input, since its magnitude 2^(WIDTH-1) is representable unsigned.
   logic             a_sign, b_sign;
   logic [WIDTH-1:0] au, bu_in;
   logic [1:0]       rmode_in;

   assign a_sign = ~bus.uns & bus.a[WIDTH-1];
   assign b_sign = ~bus.uns & bus.b[WIDTH-1];
   assign au     = a_sign ? -bus.a : bus.a;
   assign bu_in  = b_sign ? -bus.b : bus.b;

`ifdef FIXDIV_ROUND_EN
   assign rmode_in = bus.rmode;
`else
   logic unused_rmode;
   assign unused_rmode = ^bus.rmode;
   assign rmode_in     = RM_TRUNC;
`endif

   // Rounding stage inputs.
   logic [QW-1:0]    q_mag;
   logic             g_bit;
   logic             sticky;
   logic [WIDTH-1:0] rval;
   logic             rovf;

`ifdef FIXDIV_ROUND_EN
   assign q_mag = wq_reg[QW:1];
   assign g_bit = wq_reg[0];
`else
   assign q_mag = wq_reg;
   assign g_bit = 1'b0;
`endif
   assign sticky = |acc_reg;

   fixdiv_round #(
      .WIDTH (WIDTH),
      .QW    (QW)
   ) u_round (
      .q     (q_mag),
      .g     (g_bit),
      .s     (sticky),
      .rmode (rmode_reg),
      .neg   (neg_reg),
      .uns   (uns_reg),
      .val   (rval),
      .ovf   (rovf)
   );

   // Restoring step: bring down the next dividend bit, subtract if it fits.
   logic [WIDTH:0] trial;
   logic           take;

   assign trial = {acc_reg[WIDTH-1:0], wq_reg[ITER-1]};
   assign take  = (trial >= {1'b0, bu_reg});

   always_comb begin
      state_next    = state_reg;
      bu_next       = bu_reg;
      wq_next       = wq_reg;
      acc_next      = acc_reg;
      cnt_next      = cnt_reg;
      neg_next      = neg_reg;
      uns_next      = uns_reg;
      dbz_pend_next = dbz_pend_reg;
      rmode_next    = rmode_reg;
      val_next      = val_reg;
      dbz_next      = dbz_reg;
      ovf_next      = ovf_reg;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;

      case (state_reg)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               bu_next       = bu_in;
               wq_next       = ITER'(au) << (ITER - WIDTH);
               acc_next      = '0;
               cnt_next      = '0;
               neg_next      = a_sign ^ b_sign;
               uns_next      = bus.uns;
               rmode_next    = rmode_in;
               dbz_pend_next = (bus.b == '0);
               state_next    = (bus.b == '0) ? FIN : CALC;
            end
         end
         CALC: begin
            acc_next = take ? (trial - {1'b0, bu_reg}) : trial;
            wq_next  = {wq_reg[ITER-2:0], take};
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(ITER - 1)) begin
               state_next = FIN;
            end
         end
         FIN: begin
            val_next   = dbz_pend_reg ? '0 : rval;
            ovf_next   = dbz_pend_reg ? 1'b0 : rovf;
            dbz_next   = dbz_pend_reg;
            state_next = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         bu_reg       <= '0;
         wq_reg       <= '0;
         acc_reg      <= '0;
         cnt_reg      <= '0;
         neg_reg      <= 1'b0;
         uns_reg      <= 1'b0;
         dbz_pend_reg <= 1'b0;
         rmode_reg    <= RM_TRUNC;
         val_reg      <= '0;
         dbz_reg      <= 1'b0;
         ovf_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bu_reg       <= bu_next;
         wq_reg       <= wq_next;
         acc_reg      <= acc_next;
         cnt_reg      <= cnt_next;
         neg_reg      <= neg_next;
         uns_reg      <= uns_next;
         dbz_pend_reg <= dbz_pend_next;
         rmode_reg    <= rmode_next;
         val_reg      <= val_next;
         dbz_reg      <= dbz_next;
         ovf_reg      <= ovf_next;
      end
   end

   assign bus.val = val_reg;
   assign bus.dbz = dbz_reg;
   assign bus.ovf = ovf_reg;

endmodule

// File: tb/tb_fixdiv_hs.sv
// -----------------------------------------------------------------------------
// tb_fixdiv_hs
// Self-checking bench for fixdiv_hs at WIDTH=8, FBITS=4. Expected results come
// from an integer reference model and are queued when operands are accepted,
// then popped when the divider presents a result.
// -----------------------------------------------------------------------------
module tb_fixdiv_hs;

   localparam int W  = 8;
   localparam int FB = 4;
`ifdef FIXDIV_ROUND_EN
   localparam int ITER = W + FB + 1;
`else
   localparam int ITER = W + FB;
`endif

   typedef struct packed {
      logic [W-1:0] val;
      logic         dbz;
      logic         ovf;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   tests  = 0;
   int   failed = 0;
   res_t sb[$];

   always #5 clk = ~clk;

   fixdiv_hs_if #(.WIDTH(W)) bus ();

   fixdiv_hs #(
      .WIDTH (W),
      .FBITS (FB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic u, input logic [1:0] rm);
      res_t r;
      int   ma, mb, num, q, rem, m, lim, inc;
      bit   neg, g, s;
      r = '0;
      if (bv == '0) begin
         r.dbz = 1'b1;
         return r;
      end
      neg = !u && (av[W-1] != bv[W-1]);
      ma  = (!u && av[W-1]) ? (1 << W) - int'(av) : int'(av);
      mb  = (!u && bv[W-1]) ? (1 << W) - int'(bv) : int'(bv);
      num = ma << FB;
      q   = num / mb;
      rem = num % mb;
      inc = 0;
      g   = (2 * rem >= mb);
      s   = ((2 * rem - (g ? mb : 0)) != 0);
`ifdef FIXDIV_ROUND_EN
      if (rm == 2'd1)      inc = (g && (s || (q % 2 == 1))) ? 1 : 0;
      else if (rm == 2'd2) inc = g ? 1 : 0;
`else
      if (rm == 2'd3 && g && s) inc = 0;
`endif
      m   = q + inc;
      lim = u ? (1 << W) - 1 : (neg ? (1 << (W - 1)) : (1 << (W - 1)) - 1);
      if (m > lim) r.ovf = 1'b1;
      else         r.val = neg ? W'(-m) : W'(m);
      return r;
   endfunction

   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic u, input logic [1:0] rm);
      int n = 0;
      @(negedge clk);
      bus.a = av; bus.b = bv; bus.uns = u; bus.rmode = rm;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      // Scramble the operands: only the accept edge may sample them.
      bus.in_valid = 1'b0;
      bus.a = ~av; bus.b = ~bv; bus.uns = ~u; bus.rmode = ~rm;
      sb.push_back(model(av, bv, u, rm));
      $display("[TB] send a=%h b=%h uns=%0d rmode=%0d", av, bv, u, rm);
   endtask

   task automatic wait_result(input string tag, input int exp_lat, output res_t e);
      int n = 0;
      e = '0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.out_valid && n < 200);
      if (!bus.out_valid) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({tag, "_lat"}, n, exp_lat);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check({tag, "_val"}, bus.val, e.val);
      check({tag, "_dbz"}, bus.dbz, e.dbz);
      check({tag, "_ovf"}, bus.ovf, e.ovf);
      $display("[TB] %s result val=%h dbz=%0d ovf=%0d lat=%0d (exp val=%h dbz=%0d ovf=%0d)",
               tag, bus.val, bus.dbz, bus.ovf, n, e.val, e.dbz, e.ovf);
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic u, input logic [1:0] rm);
      res_t e;
      send(av, bv, u, rm);
      wait_result(tag, (bv == '0) ? 1 : ITER + 1, e);
      @(posedge clk);
      #1;
      check({tag, "_ovalid_clr"}, bus.out_valid, 1'b0);
      check({tag, "_iready"}, bus.in_ready, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t e;
      logic [W-1:0] ra, rb;
      logic         ru;
      logic [1:0]   rr;

      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.uns = 1'b0; bus.rmode = 2'd0;
      bus.out_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_val", bus.val, 8'h00);
      check("rst_dbz", bus.dbz, 1'b0);
      check("rst_ovf", bus.ovf, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("s_1p5",       8'h30, 8'h20, 1'b0, 2'd0);
      do_op("s_sixth_rm0", 8'h10, 8'h60, 1'b0, 2'd0);
      do_op("s_sixth_rm1", 8'h10, 8'h60, 1'b0, 2'd1);
      do_op("s_sixth_rm3", 8'h10, 8'h60, 1'b0, 2'd3);
      do_op("s_tie_rm0",   8'h01, 8'h20, 1'b0, 2'd0);
      do_op("s_tie_rm1",   8'h01, 8'h20, 1'b0, 2'd1);
      do_op("s_tie_rm2",   8'h01, 8'h20, 1'b0, 2'd2);
      do_op("s_neg_half",  8'hF0, 8'h20, 1'b0, 2'd0);
      do_op("s_most_neg",  8'h80, 8'h10, 1'b0, 2'd0);
      do_op("s_ovf_pos",   8'h80, 8'hF0, 1'b0, 2'd0);
      do_op("dbz",         8'h45, 8'h00, 1'b0, 2'd1);
      do_op("u_max",       8'hFF, 8'h10, 1'b1, 2'd0);
      do_op("u_ovf",       8'hFF, 8'h08, 1'b1, 2'd0);

      // Backpressure: result must hold, and new operands must be ignored.
      bus.out_ready = 1'b0;
      send(8'h30, 8'h60, 1'b0, 2'd2);
      wait_result("bp", ITER + 1, e);
      bus.in_valid = 1'b1; bus.a = 8'h11; bus.b = 8'h22;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_valid", bus.out_valid, 1'b1);
         check("bp_hold_iready", bus.in_ready, 1'b0);
         check("bp_hold_val", bus.val, e.val);
         check("bp_hold_flags", {bus.dbz, bus.ovf}, {e.dbz, e.ovf});
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", bus.out_valid, 1'b0);
      check("bp_release_iready", bus.in_ready, 1'b1);
      $display("[TB] bp released");

      // Reset in the middle of a division aborts it with no output.
      send(8'h50, 8'h30, 1'b0, 2'd1);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid, 1'b0);
      check("midrst_in_ready", bus.in_ready, 1'b1);
      sb.delete();
      $display("[TB] reset asserted mid-CALC");
      @(negedge clk);
      rst_n = 1'b1;
      do_op("post_rst", 8'h50, 8'h30, 1'b0, 2'd1);

      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         ru = 1'($urandom_range(0, 1));
         rr = 2'($urandom_range(0, 3));
         do_op("rnd", ra, rb, ru, rr);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
